// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the binary-to-BCD display feeder
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    BLANK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int          NUM_DIGITS   = 8;
  localparam int          SHIFT_CYCLES = 32;
  localparam logic [31:0] MAX_DEC      = 32'd99_999_999;
  localparam logic [31:0] OVF_PATTERN  = 32'hFFFF_FFFF;

endpackage

// File: rtl/bin2bcd_disp_if.sv
// rtl/bin2bcd_disp_if.sv - request/result bundle between the value source and the display feeder
interface bin2bcd_disp_if;
  import bin2bcd_pkg::*;

  logic                    start;
  logic [31:0]             value;
  logic                    hex_mode;
  logic                    blank_lz;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic [31:0]             disp_data;
  logic [NUM_DIGITS-1:0]   disp_en;

  modport master (
    output start, value, hex_mode, blank_lz,
    input  busy, done, ovf, disp_data, disp_en
  );

  modport slave (
    input  start, value, hex_mode, blank_lz,
    output busy, done, ovf, disp_data, disp_en
  );

endinterface

// File: rtl/bcd_add3_row.sv
// rtl/bcd_add3_row.sv - double-dabble correction: +3 on every BCD nibble that is 5 or more
module bcd_add3_row
  import bin2bcd_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  // Each nibble is corrected independently; carries only move through the following shift.
  always_comb begin
    bcd_o = bcd_i;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/bin2bcd_disp.sv
// rtl/bin2bcd_disp.sv - sequential 32-bit binary to 8-digit BCD/hex converter with leading-zero blanking
module bin2bcd_disp
  import bin2bcd_pkg::*;
(
  input  logic                 clk_100M,
  input  logic                 rst,
  bin2bcd_disp_if.slave        bus
);

  state_e                  state_q;
  logic [31:0]             bin_q;
  logic [31:0]             bcd_q;
  logic [4:0]              cnt_q;
  logic                    blank_lz_q;
  logic                    ovf_next_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ovf_q;
  logic [31:0]             disp_data_q;
  logic [NUM_DIGITS-1:0]   disp_en_q;

  logic [31:0]             bcd_adj;
  logic [NUM_DIGITS-1:0]   mask_d;

  bcd_add3_row u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

  // bcd_q doubles as the result register for hex and overflow, so the mask always scans it.
  always_comb begin
    logic seen;
    seen   = 1'b0;
    mask_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seen      = seen | (bcd_q[31-4*i -: 4] != 4'd0);
      mask_d[i] = seen | !blank_lz_q | ovf_next_q;
    end
    mask_d[NUM_DIGITS-1] = 1'b1;
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      blank_lz_q  <= 1'b0;
      ovf_next_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      disp_data_q <= '0;
      disp_en_q   <= 8'h80;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            blank_lz_q <= bus.blank_lz;
            bin_q      <= bus.value;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (bus.hex_mode) begin
              bcd_q      <= bus.value;
              ovf_next_q <= 1'b0;
              state_q    <= BLANK;
            end else if (bus.value > MAX_DEC) begin
              bcd_q      <= OVF_PATTERN;
              ovf_next_q <= 1'b1;
              state_q    <= BLANK;
            end else begin
              bcd_q      <= '0;
              ovf_next_q <= 1'b0;
              state_q    <= SHIFT;
            end
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + 5'd1;
          if (cnt_q == 5'(SHIFT_CYCLES - 1)) begin
            state_q <= BLANK;
          end
        end
        BLANK: begin
          // Outputs load together with done so the scanner never sees partial results.
          disp_data_q <= bcd_q;
          disp_en_q   <= mask_d;
          ovf_q       <= ovf_next_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.disp_data = disp_data_q;
  assign bus.disp_en   = disp_en_q;

endmodule
